// File: rtl/range_sequencer.sv
// rtl/range_sequencer.sv - single-frame buffer replaying samples as a go/finish sequence
//
// Buffers one frame of samples from a valid/ready/last stream. It then replays the
// frame to the range finder, one sample per clock, as a burst of go cycles closed
// by a finish cycle. A single-sample frame is replayed as go then finish.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   in_data      incoming sample
//   in_valid     in_data valid this cycle
//   in_last      final sample of the frame (only meaningful with in_valid)
//   in_ready     block can accept a sample (FILL or DRAIN)
//   data_out     sample to range finder; zero whenever go and finish are both low
//   go           range finder go
//   finish       range finder finish
//   busy         replaying a frame (PLAY or GAP)
//   truncated    one-cycle pulse after the accept that filled the buffer without last
//   frame_count  frames played, wraps at 255

module range_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             truncated,
  output logic [7:0]       frame_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {FILL, DRAIN, PLAY, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    n;        // samples stored in the current frame
  logic [CW-1:0]    p;        // playback step
  logic [CW-1:0]    last_p;   // step that carries finish
  logic [AW-1:0]    rd_idx;
  logic             accept;

  assign in_ready = (state == FILL) || (state == DRAIN);
  assign busy     = (state == PLAY) || (state == GAP);
  assign accept   = in_valid && in_ready;

  // A one-sample frame needs two steps (go, then finish) since the range finder
  // rejects go and finish together; longer frames finish on their last sample.
  assign last_p = (n == CW'(1)) ? CW'(1) : n - CW'(1);

  // Steps past the stored length re-read the last sample (only the n=1 finish step).
  assign rd_idx = (p >= n) ? AW'(n - CW'(1)) : AW'(p);

  // Sample storage is deliberately left unreset; n alone defines what is valid.
  always_ff @(posedge clock) begin
    if (state == FILL && accept) begin
      mem[AW'(n)] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      n           <= '0;
      p           <= '0;
      data_out    <= '0;
      go          <= 1'b0;
      finish      <= 1'b0;
      truncated   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      truncated <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            n <= n + CW'(1);
            p <= '0;
            if (in_last) begin
              state <= PLAY;
            end else if (n == CW'(DEPTH - 1)) begin
              state     <= DRAIN;
              truncated <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Buffer is full; overflow samples are consumed and dropped until last.
          if (accept && in_last) begin
            state <= PLAY;
            p     <= '0;
          end
        end
        PLAY: begin
          if (p < last_p) begin
            go       <= 1'b1;
            finish   <= 1'b0;
            data_out <= mem[rd_idx];
            p        <= p + CW'(1);
          end else if (p == last_p) begin
            go       <= 1'b0;
            finish   <= 1'b1;
            data_out <= mem[rd_idx];
            p        <= p + CW'(1);
          end else begin
            go          <= 1'b0;
            finish      <= 1'b0;
            data_out    <= '0;
            frame_count <= frame_count + 8'd1;
            state       <= GAP;
          end
        end
        GAP: begin
          n     <= '0;
          p     <= '0;
          state <= FILL;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/range_sequencer.md
# range_sequencer

Frame buffer and protocol driver directly upstream of the range finder. It accepts a stream of samples over a valid/ready handshake, delimited by a last flag, and stores one complete frame. It then replays the frame to the range finder as a go/finish sequence, one sample per clock. This keeps the downstream go/finish rules from being violated by bursty or stalled sources.

## Interface
- WIDTH, 8, sample width; matches the range finder data width
- DEPTH, 16, maximum samples per frame (≥2)
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_data  input  WIDTH  incoming sample
- in_valid  input  1  in_data valid this cycle
- in_last  input  1  qualifies in_data as final sample of frame
- in_ready  output  1  block can accept a sample; accept = in_valid & in_ready
- data_out  output  WIDTH  sample to range finder data input
- go  output  1  to range finder go
- finish  output  1  to range finder finish
- busy  output  1  high in PLAY or GAP
- truncated  output  1  one-cycle pulse: frame exceeded DEPTH
- frame_count  output  8  frames played, wraps 255→0

## Operation
- Storage: DEPTH×WIDTH array, write pointer, and sample count n (width $clog2(DEPTH+1)). Pointers restart at 0 every frame, so no wrap-around occurs. The array itself is not reset.
- States: FILL, DRAIN, PLAY, GAP. Reset state is FILL.
- FILL: in_ready=1. Each accept writes mem[n] and increments n.
  - Accept with in_last → PLAY.
  - Accept that makes n=DEPTH without in_last → DRAIN, and truncated pulses the next cycle.
- DRAIN: in_ready=1. Accepted samples are discarded. Accept with in_last → PLAY.
- PLAY: in_ready=0. Emits samples k=0..n-1 on consecutive cycles.
  - n≥2: go=1 for k<n-1; at k=n-1, finish=1 and go=0.
  - n=1: two cycles. First go=1 with s0, then finish=1 with s0 again, because the downstream block forbids go and finish in the same cycle.
  - After the finish cycle → GAP, and frame_count increments.
- GAP: one cycle with go=finish=0 and data_out=0. Then n clears and state → FILL.
- data_out is 0 whenever go and finish are both 0.
- go and finish are never high together.
- in_last with in_valid=0 is ignored.
- An accept of sample DEPTH that also carries in_last is a normal full frame: no truncation, goes directly to PLAY.

## Timing
- Reset values: in_ready=1, data_out=0, go=0, finish=0, busy=0, truncated=0, frame_count=0, n=0.
- reset asserted at any time, including mid-FILL or mid-PLAY:
  - all outputs take reset values asynchronously;
  - any partial frame is discarded;
  - go and finish drop immediately.
- data_out, go, finish and truncated are registered. in_ready and busy decode state combinationally.
- Last sample accepted at edge T: state=PLAY after T.
  - First go/data_out=s0 appears after edge T+1.
  - The sample at index k appears after edge T+1+k.
  - finish appears after edge T+n (n≥2) or T+2 (n=1).
- Outputs clear after the following edge (GAP). State returns to FILL, with in_ready=1, one edge later.
- Truncation: the DEPTH-th accept at edge T gives truncated=1 for the cycle after T.
- frame_count updates on the edge that enters GAP.

## Test plan
- Frame 5,9,2,7 (last on 7), in_valid continuous:
  - go=1 for 3 cycles with data 5,9,2;
  - then finish=1 with data 7;
  - then one zero cycle; frame_count=1;
  - in_ready=0 from the cycle after the last accept until FILL resumes.
- Single-sample frame 0x42:
  - go=1/data 0x42 for one cycle;
  - then finish=1/data 0x42 for one cycle;
  - go and finish never overlap.
- DEPTH=16, send 20 samples with last on the 20th:
  - truncated pulses once after the 16th accept;
  - samples 17–20 accepted but dropped;
  - playback emits exactly samples 1–16, finish on sample 16.
- Exactly 16 samples with last on the 16th: truncated stays 0 and playback emits all 16.
- in_valid toggled randomly during FILL: stored order and playback are unaffected by gaps, and in_ready stays 1 in FILL.
- Reset during PLAY of sample 2: go, finish and data_out go to 0 immediately, frame_count=0. Next frame plays from a clean buffer, with no stale samples.
